// File: rtl/cubic_sweep_ctrl.sv
// Sweep sequencer around cubic_fixed: issues one x per cycle, realigns returned y with its x, buffers (x, y) pairs.
// Latency: sample issued at edge k is pushed at edge k+LAT; m_valid rises after that edge.
// Backpressure: credit-based issue; stalls once FIFO occupancy plus in-flight samples reaches DEPTH.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   start                      one-cycle sweep request, ignored while busy
//   x_start, x_step, n_samples sweep description, sampled when start is accepted
//   c0, c1, c2                 coefficient set, sampled when start is accepted
//   busy, done                 sweep in progress / one-cycle completion pulse
//   cx, ca0, ca1, ca2          registered drive to cubic_fixed x, a0, a1, a2
//   cy                         y returned by cubic_fixed, LAT cycles after cx
//   m_x, m_y, m_valid, m_ready output pair stream (valid/ready), driven from the FIFO head
module cubic_sweep_ctrl #(
    parameter int WID   = 16,
    parameter int FBITS = 12,
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [WID-1:0] x_start,
    input  logic [WID-1:0] x_step,
    input  logic [15:0]    n_samples,
    input  logic [WID-1:0] c0,
    input  logic [WID-1:0] c1,
    input  logic [WID-1:0] c2,
    output logic           busy,
    output logic           done,
    output logic [WID-1:0] cx,
    output logic [WID-1:0] ca0,
    output logic [WID-1:0] ca1,
    output logic [WID-1:0] ca2,
    input  logic [WID-1:0] cy,
    output logic [WID-1:0] m_x,
    output logic [WID-1:0] m_y,
    output logic           m_valid,
    input  logic           m_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LAT + 1);
    localparam int SW = $clog2(DEPTH + LAT + 1);

    // FBITS only describes the number format seen by cubic_fixed; the
    // sequencer never does fixed-point arithmetic, so it is only range-checked.
    if (LAT < 1 || DEPTH < 1 || FBITS >= WID) begin : g_param_err
        $error("cubic_sweep_ctrl: need LAT>=1, DEPTH>=1, FBITS<WID");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_busy;
    logic           r_done;
    logic [15:0]    r_remaining;
    logic [WID-1:0] r_xnext;
    logic [WID-1:0] r_xstep;
    logic [WID-1:0] r_cx;
    logic [WID-1:0] r_ca0;
    logic [WID-1:0] r_ca1;
    logic [WID-1:0] r_ca2;

    // Tag pipeline: stage i holds the x issued i+1 edges ago.
    logic           r_tag_vld [LAT];
    logic [WID-1:0] r_tag_x   [LAT];
    logic [IW-1:0]  r_inflight;

    // Output FIFO.
    logic [WID-1:0] r_fifo_x [DEPTH];
    logic [WID-1:0] r_fifo_y [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic w_push;
    logic w_pop;
    logic w_credit_ok;
    logic w_issue;
    logic w_drained;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // cubic_fixed cannot stall, so every sample issued must already own a
    // FIFO slot: occupancy plus in-flight samples is the credit in use.
    assign w_push      = r_tag_vld[LAT-1];
    assign w_pop       = (r_count != '0) && m_ready;
    assign w_credit_ok = (SW'(r_count) + SW'(r_inflight)) < SW'(DEPTH);
    assign w_issue     = (r_state == S_RUN) && (r_remaining != 16'd0) && w_credit_ok;

    // Leave RUN on the edge of the last handshake so done follows one edge
    // later. No in-flight samples means no push can land on this edge.
    assign w_drained = (r_remaining == 16'd0) && (r_inflight == '0) &&
                       ((r_count == '0) || ((r_count == CW'(1)) && w_pop));

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            r_xnext     <= '0;
            r_xstep     <= '0;
            r_cx        <= '0;
            r_ca0       <= '0;
            r_ca1       <= '0;
            r_ca2       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_ca0       <= c0;
                        r_ca1       <= c1;
                        r_ca2       <= c2;
                        r_remaining <= n_samples;
                        r_xnext     <= x_start;
                        r_xstep     <= x_step;
                        r_state     <= (n_samples == 16'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_cx        <= r_xnext;
                        r_xnext     <= r_xnext + r_xstep;
                        r_remaining <= r_remaining - 16'd1;
                    end
                    if (w_drained) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipeline and in-flight counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_tag_vld[i] <= 1'b0;
                r_tag_x[i]   <= '0;
            end
            r_inflight <= '0;
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_x[0]   <= r_xnext;
            for (int i = 1; i < LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_x[i]   <= r_tag_x[i-1];
            end
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Output FIFO. Storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_x[i] <= '0;
                r_fifo_y[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_x[r_wr_ptr] <= r_tag_x[LAT-1];
                r_fifo_y[r_wr_ptr] <= cy;
                r_wr_ptr           <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign cx      = r_cx;
    assign ca0     = r_ca0;
    assign ca1     = r_ca1;
    assign ca2     = r_ca2;
    // Head entry is never overwritten while occupied, so it holds under stall.
    assign m_x     = r_fifo_x[r_rd_ptr];
    assign m_y     = r_fifo_y[r_rd_ptr];
    assign m_valid = (r_count != '0);

endmodule

// File: doc/cubic_sweep_ctrl.md
# cubic_sweep_ctrl

Sweep sequencer and output buffer placed directly upstream and downstream of `cubic_fixed`. On `start`, it latches a coefficient set and an x-sweep description, then drives `cubic_fixed` with one x per cycle. It realigns each returned y with its x through a latency-matched tag pipeline and presents (x, y) pairs on a valid/ready stream. Credit-based issue keeps results from being lost, because `cubic_fixed` has no stall input.

## Interface
Parameters:
- `WID`, 16: data width of x, coefficients and y (signed two's complement).
- `FBITS`, 12: fractional bits. Passed through only and not used in this block's arithmetic.
- `LAT`, 3: cycles from a `cx` change to the matching `cy` being valid at `cubic_fixed`'s output. Must be ≥1.
- `DEPTH`, 4: output FIFO entries. Must be ≥ LAT+1 for full throughput and ≥1 for correctness.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle request to begin a sweep. Ignored while `busy`=1.
- `x_start`  in  WID  first x of the sweep. Sampled when `start` is accepted.
- `x_step`  in  WID  signed x increment. Sampled when `start` is accepted.
- `n_samples`  in  16  number of samples. Sampled when `start` is accepted.
- `c0`, `c1`, `c2`  in  WID each  coefficients. Sampled when `start` is accepted.
- `busy`  out  1  high from an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `cx`, `ca0`, `ca1`, `ca2`  out  WID each  registered drive to `cubic_fixed` `x`, `a0`, `a1`, `a2`.
- `cy`  in  WID  `y` from `cubic_fixed`.
- `m_x`, `m_y`  out  WID each  output pair, taken from the FIFO head.
- `m_valid`  out  1  the FIFO is non-empty.
- `m_ready`  in  1  the consumer accepts the pair.

## Operation
The state machine has three states:
- **IDLE**
  - When `start`=1: latch all sweep inputs; `ca0/ca1/ca2` ← `c0/c1/c2`; `remaining` ← `n_samples`; `xnext` ← `x_start`.
  - If `n_samples`=0, go to DONE. Otherwise go to RUN.
- **RUN**
  - Each cycle, issue a sample if `remaining`≠0 and `fifo_count + inflight < DEPTH`.
  - An issue does the following: `cx` ← `xnext`; `xnext` ← `xnext + x_step` (mod 2^WID, wraps, no saturation); `remaining`−1; a valid bit carrying x enters the tag pipeline.
  - Go to DONE when `remaining`=0, `inflight`=0, the FIFO is empty, and there is no handshake pending.
- **DONE**
  - `done`=1 for one cycle, then return to IDLE.

Tag pipeline:
- LAT stages of {valid, x}.
- The stage-LAT output being valid pushes {x, `cy`} into the FIFO.
- `inflight` is the number of valid bits in the pipeline.

FIFO:
- Depth `DEPTH`, with circular pointers that wrap at DEPTH.
- A pop happens on `m_valid & m_ready`.
- A push and a pop in the same cycle are both allowed, and the count is unchanged.
- A push never occurs while the FIFO is full; the credit check guarantees this.
- `m_x`/`m_y` are held stable while `m_valid`=1 and `m_ready`=0.

Other behaviour:
- `cx` holds its last issued value between issues. Coefficient outputs hold after the sweep ends.
- `start` while `busy` is dropped, with no effect on the latched values.
- Reset (asynchronous, any time, including mid-sweep):
  - State → IDLE.
  - The FIFO and tag pipeline are emptied, and in-flight results are discarded.
  - The following outputs go to 0: `busy`, `done`, `m_valid`, `cx`, `ca0`, `ca1`, `ca2`, `m_x`, `m_y`.

## Timing
- `start` accepted at edge t:
  - `busy`=1 after edge t.
  - The first issue can occur at edge t+1, which updates `cx`.
- Sample issued at edge k:
  - Its y is pushed at edge k+LAT.
  - `m_valid` rises after edge k+LAT. It is registered, with no combinational path from `cy`.
- Throughput: 1 sample/cycle sustained when `m_ready`=1 and DEPTH ≥ LAT+1.
- Backpressure: issue stalls once `fifo_count + inflight` = DEPTH. It resumes the cycle after a pop.
- Completion:
  - After the last handshake at edge h, the state enters DONE.
  - `done`=1 and `busy`=0 after edge h+1.
  - `done` clears after edge h+2.
- `n_samples`=0: `done` pulses after edge t+1, with no `cx` change and no output.
- `m_ready` has no combinational path to any output except through registers.

## Test plan
- **Basic sweep.** LAT=3, `x_start`=0x1000 (1.0), `x_step`=0x0400, `n_samples`=4, `c0`=`c1`=`c2`=0, `m_ready`=1 → y = x³ gives output pairs (0x1000,0x1000), (0x1400,0x1F40), (0x1800,0x3600), (0x1C00,0x55C0). They arrive on 4 consecutive cycles, and `done` pulses once.
- **Backpressure.** Same sweep with `m_ready`=0 for 10 cycles, then 1 → at most DEPTH=4 issues occur. Stall at (x=0x1000,y=0x1000): `m_valid`=1 and `m_x`/`m_y` hold stable. No sample is lost or duplicated. Order is preserved.
- **Wrap-around.** `x_start`=0x7FFF, `x_step`=0x0001, `n_samples`=2 → `cx` sequence is 0x7FFF then 0x8000. Output x tags match.
- **Zero length and start while busy.**
  - `n_samples`=0 → `done` pulses one cycle after start, and `m_valid` never rises.
  - `start` pulsed mid-sweep with different coefficients → ignored, and the outputs match the original coefficients.
- **Reset mid-sweep.** `rst` asserted asynchronously after 2 issues of a 10-sample sweep → all outputs are 0 immediately. After release, a new sweep of 3 samples produces exactly 3 correct pairs and no stale data.
- **Full polynomial.** `c0`=0x1000, `c1`=0x2000, `c2`=0xF000 (−1.0), x=0x1000, `n_samples`=1 → y = 1 − 1 + 2 + 1 = 3.0 = 0x3000.
